// File: rtl/tx_ffe_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tx_ffe_sweep_ctrl
// Brief    : TX FFE link-training sweep controller. Steps tx_setting from
//            SETTING_MIN to SETTING_MAX. For each setting it waits a settle
//            window, then counts RX error strobes over a measurement window.
//            At the end it programs the FFE with the setting that gave the
//            fewest errors. Ties are resolved toward the earlier setting.
// Revision : 1.0 - initial release
// ============================================================================
module tx_ffe_sweep_ctrl #(
  parameter int unsigned TX_SETTING_WIDTH = 4,
  parameter int unsigned SETTING_MIN      = 0,
  parameter int unsigned SETTING_MAX      = 2**TX_SETTING_WIDTH - 1,
  parameter int unsigned DEFAULT_SETTING  = 0,
  parameter int unsigned SETTLE_CYCLES    = 64,
  parameter int unsigned MEAS_CYCLES      = 1024,
  parameter int unsigned ERR_CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        err,
  output logic [TX_SETTING_WIDTH-1:0] tx_setting,
  output logic                        busy,
  output logic                        done,
  output logic [TX_SETTING_WIDTH-1:0] best_setting,
  output logic [ERR_CNT_WIDTH-1:0]    best_err
);

  // One shared cycle counter serves both the settle and measure windows.
  // It is therefore sized for the longer of the two.
  localparam int unsigned CYC_MAX = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int unsigned CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  localparam logic [CYC_W-1:0]            C_SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0]            C_MEAS_LAST   = CYC_W'(MEAS_CYCLES - 1);
  localparam logic [TX_SETTING_WIDTH-1:0] C_MIN         = TX_SETTING_WIDTH'(SETTING_MIN);
  localparam logic [TX_SETTING_WIDTH-1:0] C_MAX         = TX_SETTING_WIDTH'(SETTING_MAX);
  localparam logic [TX_SETTING_WIDTH-1:0] C_DEFAULT     = TX_SETTING_WIDTH'(DEFAULT_SETTING);
  localparam logic [ERR_CNT_WIDTH-1:0]    C_ERR_SAT     = '1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                      state_q;
  logic [TX_SETTING_WIDTH-1:0] tx_setting_q;
  logic [TX_SETTING_WIDTH-1:0] restore_q;
  logic [TX_SETTING_WIDTH-1:0] best_setting_q;
  logic [ERR_CNT_WIDTH-1:0]    best_err_q;
  logic [ERR_CNT_WIDTH-1:0]    err_cnt_q;
  logic [CYC_W-1:0]            cyc_q;
  // Set once the first point of the current sweep has been compared.
  logic                        seen_q;

  logic                        busy_d;
  logic [ERR_CNT_WIDTH-1:0]    err_cnt_d;
  logic                        accept_d;
  logic [TX_SETTING_WIDTH-1:0] final_best_d;

  // Decode busy from the registered state.
  // Compute the saturating error increment.
  // Decide whether the current point beats the best so far.
  always_comb begin
    busy_d       = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) ||
                   (state_q == ST_COMPARE);
    err_cnt_d    = (err_cnt_q == C_ERR_SAT) ? err_cnt_q
                                            : err_cnt_q + ERR_CNT_WIDTH'(1);
    // Strict less-than keeps the earlier (lower) setting on a tie.
    accept_d     = !seen_q || (err_cnt_q < best_err_q);
    // The final programmed value must include this cycle's accept.
    final_best_d = accept_d ? tx_setting_q : best_setting_q;
  end

  // Sweep sequencer: state, setting bus, window counters and best tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      tx_setting_q   <= C_DEFAULT;
      restore_q      <= C_DEFAULT;
      best_setting_q <= C_DEFAULT;
      best_err_q     <= C_ERR_SAT;
      err_cnt_q      <= '0;
      cyc_q          <= '0;
      seen_q         <= 1'b0;
    end else if (abort && busy_d) begin
      // Abort wins over every other transition.
      // The FFE is put back to the value it had before the sweep.
      // Best results are left untouched.
      state_q      <= ST_IDLE;
      tx_setting_q <= restore_q;
      cyc_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_SETTLE;
            restore_q    <= tx_setting_q;
            tx_setting_q <= C_MIN;
            best_err_q   <= C_ERR_SAT;
            seen_q       <= 1'b0;
            cyc_q        <= '0;
          end
        end

        ST_SETTLE: begin
          // err is deliberately ignored while the FFE and channel settle.
          if (cyc_q == C_SETTLE_LAST) begin
            state_q   <= ST_MEASURE;
            cyc_q     <= '0;
            err_cnt_q <= '0;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end

        ST_MEASURE: begin
          if (err) begin
            err_cnt_q <= err_cnt_d;
          end
          if (cyc_q == C_MEAS_LAST) begin
            state_q <= ST_COMPARE;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end

        ST_COMPARE: begin
          seen_q <= 1'b1;
          if (accept_d) begin
            best_setting_q <= tx_setting_q;
            best_err_q     <= err_cnt_q;
          end
          if (tx_setting_q != C_MAX) begin
            tx_setting_q <= tx_setting_q + TX_SETTING_WIDTH'(1);
            state_q      <= ST_SETTLE;
          end else begin
            tx_setting_q <= final_best_d;
            state_q      <= ST_DONE;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_setting   = tx_setting_q;
  assign best_setting = best_setting_q;
  assign best_err     = best_err_q;
  assign busy         = busy_d;
  assign done         = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_tx_ffe_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_ffe_sweep_ctrl
// Brief    : Self-checking bench for tx_ffe_sweep_ctrl. Two instances are used:
//            one with MEAS=8 and one with MEAS=20 for the saturation case.
//            Expected values come from a per-cycle arithmetic model of the
//            sweep timeline and a running min-search over error counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_ffe_sweep_ctrl;

  localparam int W   = 4;
  localparam int MIN = 0;
  localparam int MAX = 3;
  localparam int DEF = 2;
  localparam int S   = 4;
  localparam int EW  = 4;
  localparam int N   = MAX - MIN + 1;
  localparam int SAT = (1 << EW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, abort = 1'b0, err = 1'b0, sel = 1'b0;
  logic start_a, start_b;
  logic [W-1:0]  tx_a, tx_b, bs_a, bs_b, obs_tx, obs_bs;
  logic [EW-1:0] be_a, be_b, obs_be;
  logic busy_a, busy_b, done_a, done_b, obs_busy, obs_done;

  int errors = 0;
  int checks = 0;
  int m_tx[2], m_bs[2], m_be[2];
  int pat[N];

  always #5 clk = ~clk;

  assign start_a  = start & ~sel;
  assign start_b  = start & sel;
  assign obs_tx   = sel ? tx_b   : tx_a;
  assign obs_bs   = sel ? bs_b   : bs_a;
  assign obs_be   = sel ? be_b   : be_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_done = sel ? done_b : done_a;

  tx_ffe_sweep_ctrl #(.TX_SETTING_WIDTH(W), .SETTING_MIN(MIN), .SETTING_MAX(MAX),
    .DEFAULT_SETTING(DEF), .SETTLE_CYCLES(S), .MEAS_CYCLES(8), .ERR_CNT_WIDTH(EW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort), .err(err),
    .tx_setting(tx_a), .busy(busy_a), .done(done_a), .best_setting(bs_a), .best_err(be_a));

  tx_ffe_sweep_ctrl #(.TX_SETTING_WIDTH(W), .SETTING_MIN(MIN), .SETTING_MAX(MAX),
    .DEFAULT_SETTING(DEF), .SETTLE_CYCLES(S), .MEAS_CYCLES(20), .ERR_CNT_WIDTH(EW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort), .err(err),
    .tx_setting(tx_b), .busy(busy_b), .done(done_b), .best_setting(bs_b), .best_err(be_b));

  // One sweep on instance s.
  // mode 0: pattern pat[] (first pat[i] measure cycles high).
  // mode 1: random err.
  // mode 2: err constantly high.
  // abort_k / rst_k: cycle (1 = first SETTLE cycle) in which abort/rst is driven (-1 = never).
  task automatic sweep(input bit s, input int mode, input int abort_k, input int rst_k,
                       input bit spam, input bit ab_edges, input string tag);
    int m, p, restore, cnt, bset, berr, idx, ph, e_tx, e_bs, e_be, term;
    bit first, e_busy, e_done;
    m = s ? 20 : 8;
    p = S + m + 1;
    restore = m_tx[s]; bset = m_bs[s]; berr = SAT; first = 1; cnt = 0; term = 0;
    @(negedge clk);
    sel = s; start = 1'b1; abort = ab_edges; err = 1'($urandom);
    for (int k = 1; k <= N*p + 2 && term == 0; k++) begin
      @(negedge clk);
      idx = (k - 1) / p;
      ph  = (k - 1) % p;
      if (k == rst_k + 1) begin
        e_tx = DEF; e_bs = DEF; e_be = SAT; e_busy = 0; e_done = 0; term = 2;
      end else if (k == abort_k + 1) begin
        e_tx = restore; e_bs = bset; e_be = berr; e_busy = 0; e_done = 0; term = 1;
      end else if (k <= N*p) begin
        e_tx = MIN + idx; e_bs = bset; e_be = berr; e_busy = 1; e_done = 0;
      end else begin
        e_tx = bset; e_bs = bset; e_be = berr; e_busy = 0; e_done = (k == N*p + 1);
      end
      checks++;
      if (obs_tx !== 4'(e_tx)) begin
        errors++;
        $display("FAIL %s k=%0d tx_setting: got %0d expected %0d", tag, k, obs_tx, e_tx);
      end
      checks++;
      if (obs_busy !== e_busy) begin
        errors++;
        $display("FAIL %s k=%0d busy: got %0b expected %0b", tag, k, obs_busy, e_busy);
      end
      checks++;
      if (obs_done !== e_done) begin
        errors++;
        $display("FAIL %s k=%0d done: got %0b expected %0b", tag, k, obs_done, e_done);
      end
      checks++;
      if (obs_bs !== 4'(e_bs)) begin
        errors++;
        $display("FAIL %s k=%0d best_setting: got %0d expected %0d", tag, k, obs_bs, e_bs);
      end
      checks++;
      if (obs_be !== 4'(e_be)) begin
        errors++;
        $display("FAIL %s k=%0d best_err: got %0d expected %0d", tag, k, obs_be, e_be);
      end
      if (term != 0) begin
        start = 1'b0; abort = 1'b0; rst = 1'b0; err = 1'b0;
      end else begin
        start = (spam && k <= N*p + 1) ? 1'($urandom) : 1'b0;
        abort = (k == abort_k) || (ab_edges && k == N*p + 1);
        rst   = (k == rst_k);
        if (mode == 2) err = 1'b1;
        else if (mode == 0 && k <= N*p && ph >= S && ph < S + m) err = ((ph - S) < pat[idx]);
        else err = ($urandom % 3 == 0);
        // Model: count errors of this setting, then pick the strict minimum.
        if (k <= N*p && k != abort_k && k != rst_k) begin
          if (ph >= S && ph < S + m && err) cnt = (cnt < SAT) ? cnt + 1 : SAT;
          if (ph == S + m) begin
            if (first || cnt < berr) begin bset = MIN + idx; berr = cnt; end
            first = 0;
            cnt = 0;
          end
        end
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0; err = 1'b0;
    if (term == 2) begin
      for (int i = 0; i < 2; i++) begin m_tx[i] = DEF; m_bs[i] = DEF; m_be[i] = SAT; end
    end else if (term == 1) begin
      m_tx[s] = restore; m_bs[s] = bset; m_be[s] = berr;
    end else begin
      m_tx[s] = bset; m_bs[s] = bset; m_be[s] = berr;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      m_tx[i] = DEF; m_bs[i] = DEF; m_be[i] = SAT;
      checks++;
      if (obs_tx !== 4'(DEF) || obs_bs !== 4'(DEF)) begin
        errors++;
        $display("FAIL reset_setting inst=%0d: got tx=%0d best=%0d expected %0d", i, obs_tx, obs_bs, DEF);
      end
      checks++;
      if (obs_be !== 4'(SAT) || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags inst=%0d: got best_err=%0d busy=%0b done=%0b expected 15/0/0",
                 i, obs_be, obs_busy, obs_done);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    // Abort on the third MEASURE cycle of setting 1 (cycle 13 + 4 + 2 + 1).
    sweep(1'b0, 1, 20, -1, 1'b0, 1'b0, "abort");
  endtask

  task automatic test_full_sweep();
    pat[0] = 5; pat[1] = 1; pat[2] = 3; pat[3] = 2;
    sweep(1'b0, 0, -1, -1, 1'b0, 1'b0, "full_sweep");
    checks++;
    if (obs_tx !== 4'd1 || obs_be !== 4'd1) begin
      errors++;
      $display("FAIL full_sweep_final: got tx=%0d best_err=%0d expected 1/1", obs_tx, obs_be);
    end
  endtask

  task automatic test_start_while_busy();
    pat[0] = 5; pat[1] = 1; pat[2] = 3; pat[3] = 2;
    sweep(1'b0, 0, -1, -1, 1'b1, 1'b0, "start_busy");
  endtask

  task automatic test_tie_sat();
    pat[0] = 0; pat[1] = 3; pat[2] = 0; pat[3] = 8;
    sweep(1'b0, 0, -1, -1, 1'b0, 1'b0, "tie");
    checks++;
    if (obs_bs !== 4'd0 || obs_be !== 4'd0) begin
      errors++;
      $display("FAIL tie_final: got best=%0d best_err=%0d expected 0/0", obs_bs, obs_be);
    end
    sweep(1'b1, 2, -1, -1, 1'b0, 1'b0, "saturate");
    checks++;
    if (obs_bs !== 4'd0 || obs_be !== 4'd15) begin
      errors++;
      $display("FAIL saturate_final: got best=%0d best_err=%0d expected 0/15", obs_bs, obs_be);
    end
    sel = 1'b0;
  endtask

  task automatic test_start_abort_edges();
    // start+abort together in IDLE starts the sweep; abort in DONE is ignored.
    sweep(1'b0, 1, -1, -1, 1'b0, 1'b1, "start_abort");
  endtask

  task automatic test_reset_mid();
    sweep(1'b0, 1, -1, 2*13 + 1, 1'b0, 1'b0, "reset_mid");
    sweep(1'b0, 1, -1, -1, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_idle_abort();
    sel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      abort = 1'b1; err = 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs_tx !== 4'(m_tx[0]) || obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_bs !== 4'(m_bs[0])) begin
        errors++;
        $display("FAIL idle_abort: got tx=%0d busy=%0b done=%0b best=%0d expected tx=%0d best=%0d",
                 obs_tx, obs_busy, obs_done, obs_bs, m_tx[0], m_bs[0]);
      end
    end
    abort = 1'b0; err = 1'b0;
  endtask

  task automatic test_random();
    int s, ak;
    for (int r = 0; r < 8; r++) begin
      s  = $urandom % 2;
      ak = ($urandom % 2 == 0) ? -1 : 1 + int'($urandom % (N * (S + (s ? 20 : 8) + 1)));
      sweep(s[0], 1, ak, -1, 1'($urandom), 1'($urandom), "random");
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_abort();
    test_full_sweep();
    test_start_while_busy();
    test_tie_sat();
    test_start_abort_edges();
    test_reset_mid();
    test_idle_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_ffe_sweep_ctrl.md
# tx_ffe_sweep_ctrl

Link-training controller that owns the `tx_setting` bus of the TX FFE. On `start` it sweeps `tx_setting` from `SETTING_MIN` to `SETTING_MAX`. For each setting it waits a settle window covering FFE ROM latency plus channel and RX pipeline delay, then counts RX bit-error strobes over a fixed measurement window. When the sweep completes it leaves the FFE programmed with the setting that produced the fewest errors. It sits between the RX PRBS checker (error strobe) and the TX FFE (setting input), under control of the top-level link bring-up logic.

## Interface
- `TX_SETTING_WIDTH`, 4: width of `tx_setting`; matches the FFE ROM setting field.
- `SETTING_MIN`, 0: first setting swept.
- `SETTING_MAX`, 2**TX_SETTING_WIDTH-1: last setting swept; requires `SETTING_MAX >= SETTING_MIN`.
- `DEFAULT_SETTING`, 0: setting driven out of reset.
- `SETTLE_CYCLES`, 64: cycles spent in SETTLE per setting; must be >= 1.
- `MEAS_CYCLES`, 1024: cycles spent in MEASURE per setting; must be >= 1.
- `ERR_CNT_WIDTH`, 16: error counter width.

Ports:
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begins a sweep. Sampled only in IDLE.
- `abort`, input, 1: cancels a sweep in progress.
- `err`, input, 1: per-cycle bit-error strobe from the RX checker.
- `tx_setting`, output, TX_SETTING_WIDTH: registered; drives the FFE.
- `busy`, output, 1: high in SETTLE, MEASURE and COMPARE.
- `done`, output, 1: one-cycle pulse at the end of a completed sweep.
- `best_setting`, output, TX_SETTING_WIDTH: best setting found so far.
- `best_err`, output, ERR_CNT_WIDTH: error count of `best_setting`.

## Operation
- States: IDLE, SETTLE, MEASURE, COMPARE, DONE.
- Reset values:
  - state = IDLE.
  - `tx_setting` = `best_setting` = `DEFAULT_SETTING`.
  - `best_err` = all ones.
  - `busy` = `done` = 0.
  - internal counters = 0.
- IDLE, `start`=1 → SETTLE:
  - `tx_setting` ← `SETTING_MIN`.
  - Save the current `tx_setting` as `restore_setting`.
  - Clear the first-point flag.
  - `best_err` ← all ones.
- SETTLE: hold for `SETTLE_CYCLES` cycles and ignore `err`. Then go to MEASURE with the error counter cleared.
- MEASURE: hold for `MEAS_CYCLES` cycles. Each cycle with `err`=1 increments the counter, saturating at 2**ERR_CNT_WIDTH-1 (no wrap). Then go to COMPARE.
- COMPARE (1 cycle):
  - Accept the point if it is the first point of the sweep, or if count < `best_err` (strict less-than). Ties keep the lower, earlier setting.
  - On accept: `best_setting` ← `tx_setting`, `best_err` ← count.
  - If `tx_setting` != `SETTING_MAX`: `tx_setting` ← `tx_setting`+1 and go to SETTLE.
  - Otherwise: `tx_setting` ← the final best, including this cycle's accept, and go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- In IDLE, `tx_setting` holds its last value.
- `abort`=1 in SETTLE, MEASURE or COMPARE:
  - Next state is IDLE.
  - `tx_setting` ← `restore_setting`.
  - `best_setting` and `best_err` hold their current values.
  - No `done` pulse.
  - `abort` takes priority over every other transition.
- `abort` in IDLE or DONE has no effect.
- `start` outside IDLE is ignored.
- `start` and `abort` both high in IDLE: the sweep starts.
- `rst` mid-sweep: all registers return to their reset values on the next edge.

## Timing
- `start` high at edge t → state SETTLE and `tx_setting`=`SETTING_MIN` visible after edge t.
- Each setting occupies `SETTLE_CYCLES` + `MEAS_CYCLES` + 1 cycles.
- `err` is counted only in the cycles where state is MEASURE at the sampling edge.
- `tx_setting` changes only on entry to SETTLE, on entry to DONE, or on abort/reset. It is stable throughout SETTLE and MEASURE.
- N = `SETTING_MAX`-`SETTING_MIN`+1. `done` is high during cycle t + N·(`SETTLE_CYCLES`+`MEAS_CYCLES`+1) + 1, counting the first SETTLE cycle as t+1.
- `best_setting`/`best_err` update the edge after COMPARE and are valid when `done` is high.
- `busy` is a function of state only: registered state, combinational decode.

## Test plan
All scenarios use MIN=0, MAX=3, SETTLE=4, MEAS=8, ERR_CNT_WIDTH=4, DEFAULT=2.
- **Reset:** assert `rst` 2 cycles → `tx_setting`=2, `best_setting`=2, `best_err`=15, `busy`=0, `done`=0.
- **Full sweep:** `start` pulse; `err` asserted in 5, 1, 3, 2 MEASURE cycles for settings 0..3 → `tx_setting` steps 0,1,2,3 at 13-cycle intervals; `done` pulses 53 cycles after `start`; final `tx_setting`=1, `best_err`=1.
- **Tie and saturation:** settings 0 and 2 both see 0 errors, and `err` is held high throughout MEASURE for setting 3 → `best_setting`=0; counter for setting 3 reads 8 (no overflow). Separately, with MEAS=20 and `err` constantly high for every setting → counters saturate at 15; first point accepted, so `best_setting`=0, `best_err`=15.
- **Abort:** after reset (`tx_setting`=2), `start`; raise `abort` during MEASURE of setting 1 → IDLE next cycle, `tx_setting`=2, no `done`, `busy`=0.
- **Start while busy:** pulse `start` repeatedly mid-sweep → sweep sequence and `done` timing identical to the Full sweep scenario.
- **Reset mid-sweep:** `rst` in SETTLE of setting 2 → reset values next cycle; a new `start` then runs a full 53-cycle sweep.
